// File: rtl/frame_generator.sv
// Self-timed framer: owns row/column position, builds FAS/MFAS/overhead/payload/stuff
// bytes and pulls payload from the client through a ready/valid handshake.
module frame_generator #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 1041,
    parameter int OH_COLS  = 16,
    parameter int MFAS_EN  = 1,
    parameter int ROW_W    = $clog2(NUM_ROWS),
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr_stats,
    input  logic [7:0]       i_pyld_data,
    input  logic             i_pyld_data_valid,
    output logic             o_pyld_ready,
    output logic [7:0]       o_frame_data,
    output logic             o_frame_data_valid,
    output logic             o_frame_data_fas,
    output logic [ROW_W-1:0] o_row_cnt,
    output logic [COL_W-1:0] o_col_cnt,
    output logic [7:0]       o_mfas,
    output logic [15:0]      o_underflow_cnt,
    output logic             o_running
);

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] FIRST_PYLD = COL_W'(OH_COLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [7:0]       r_mfas;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_fas;
    logic [15:0]      r_uf_cnt;

    logic             w_active;
    logic             w_last_pos;
    logic             w_pyld_ready;
    logic             w_row0;
    logic [7:0]       w_byte;

    assign w_active     = (r_state != S_IDLE);
    assign w_last_pos   = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_row0       = (r_row == '0);
    assign w_pyld_ready = w_active && (r_col >= FIRST_PYLD) && (r_col != LAST_COL);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_en) w_state_next = S_RUN;
            S_RUN:   if (!i_en) w_state_next = w_last_pos ? S_IDLE : S_STOP;
            // A frame already started always runs to its last byte
            S_STOP:  if (w_last_pos) w_state_next = i_en ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_mfas <= 8'h00;
        end else if (w_active) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if (w_last_pos) begin
                r_mfas <= r_mfas + 8'd1;
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        if (w_row0 && r_col < COL_W'(3)) begin
            w_byte = 8'hF6;
        end else if (w_row0 && r_col < COL_W'(6)) begin
            w_byte = 8'h28;
        end else if (w_row0 && r_col == COL_W'(6)) begin
            w_byte = (MFAS_EN != 0) ? r_mfas : 8'h00;
        end else if (w_pyld_ready && i_pyld_data_valid) begin
            w_byte = i_pyld_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_fas   <= 1'b0;
        end else if (w_active) begin
            r_data  <= w_byte;
            r_valid <= 1'b1;
            r_fas   <= w_row0 && (r_col == '0);
        end else begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_fas   <= 1'b0;
        end
    end

    // Clear has priority over a same-cycle underflow increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_uf_cnt <= 16'h0000;
        end else if (i_clr_stats) begin
            r_uf_cnt <= 16'h0000;
        end else if (w_pyld_ready && !i_pyld_data_valid && r_uf_cnt != 16'hFFFF) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign o_pyld_ready       = w_pyld_ready;
    assign o_frame_data       = r_data;
    assign o_frame_data_valid = r_valid;
    assign o_frame_data_fas   = r_fas;
    assign o_row_cnt          = r_row;
    assign o_col_cnt          = r_col;
    assign o_mfas             = r_mfas;
    assign o_underflow_cnt    = r_uf_cnt;
    assign o_running          = w_active;

endmodule

// File: tb/tb_frame_generator.sv
// Bench for frame_generator: a default-size instance for the header check and a
// small instance driven with random traffic against a linear-position reference model.
module tb_frame_generator;

    localparam int SR  = 2;
    localparam int SC  = 24;
    localparam int SOH = 16;
    localparam int BR  = 4;
    localparam int BC  = 1041;
    localparam int BOH = 16;

    logic        clk;
    logic        rst;

    logic        s_en, s_clr, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, s_fvalid, s_ffas, s_running;
    logic [7:0]  s_fdata, s_mfas;
    logic [0:0]  s_row;
    logic [4:0]  s_col;
    logic [15:0] s_ucnt;

    logic        b_en, b_clr, b_valid;
    logic [7:0]  b_data;
    logic        b_ready, b_fvalid, b_ffas, b_running;
    logic [7:0]  b_fdata, b_mfas;
    logic [1:0]  b_row;
    logic [10:0] b_col;
    logic [15:0] b_ucnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame is a linear run of SR*SC positions
    bit m_gen;
    int m_p;
    int m_mfas;
    int m_ucnt;

    frame_generator #(.NUM_ROWS(SR), .NUM_COLS(SC), .OH_COLS(SOH), .MFAS_EN(1)) u_small (
        .i_clk(clk), .i_rst(rst), .i_en(s_en), .i_clr_stats(s_clr),
        .i_pyld_data(s_data), .i_pyld_data_valid(s_valid), .o_pyld_ready(s_ready),
        .o_frame_data(s_fdata), .o_frame_data_valid(s_fvalid), .o_frame_data_fas(s_ffas),
        .o_row_cnt(s_row), .o_col_cnt(s_col), .o_mfas(s_mfas),
        .o_underflow_cnt(s_ucnt), .o_running(s_running)
    );

    frame_generator u_big (
        .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_clr_stats(b_clr),
        .i_pyld_data(b_data), .i_pyld_data_valid(b_valid), .o_pyld_ready(b_ready),
        .o_frame_data(b_fdata), .o_frame_data_valid(b_fvalid), .o_frame_data_fas(b_ffas),
        .o_row_cnt(b_row), .o_col_cnt(b_col), .o_mfas(b_mfas),
        .o_underflow_cnt(b_ucnt), .o_running(b_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        int c;
        c = m_p % SC;
        return m_gen && (c >= SOH) && (c != SC - 1);
    endfunction

    task automatic model_reset();
        m_gen  = 1'b0;
        m_p    = 0;
        m_mfas = 0;
        m_ucnt = 0;
    endtask

    // One clock on the small instance; entered and left at posedge+1
    task automatic step(input bit en, input bit v, input logic [7:0] d, input bit clr);
        int r, c;
        bit rdy, exp_valid, exp_fas;
        logic [7:0] eb;
        s_en = en; s_valid = v; s_data = d; s_clr = clr;
        r = m_p / SC;
        c = m_p % SC;
        rdy = model_ready();
        #1;
        check_eq("ready", s_ready, rdy);
        check_eq("row", s_row, r);
        check_eq("col", s_col, c);
        check_eq("running", s_running, m_gen);
        check_eq("mfas", s_mfas, m_mfas);
        eb = 8'h00;
        if (m_gen) begin
            if (r == 0 && c < 3)       eb = 8'hF6;
            else if (r == 0 && c < 6)  eb = 8'h28;
            else if (r == 0 && c == 6) eb = 8'(m_mfas);
            else if (rdy && v)         eb = d;
        end
        exp_valid = m_gen;
        exp_fas   = m_gen && (m_p == 0);
        if (clr) m_ucnt = 0;
        else if (rdy && !v && m_ucnt < 65535) m_ucnt++;
        if (m_gen) begin
            if (m_p == SR * SC - 1) begin
                m_p    = 0;
                m_mfas = (m_mfas + 1) % 256;
                m_gen  = en;
            end else begin
                m_p++;
            end
        end else if (en) begin
            m_gen = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("data", s_fdata, eb);
        check_eq("valid", s_fvalid, exp_valid);
        check_eq("fas", s_ffas, exp_fas);
        check_eq("uf_cnt", s_ucnt, m_ucnt);
    endtask

    task automatic run_header();
        int p, r, c;
        bit rdy, rdy_dut;
        logic [7:0] b, pe, eb;
        b = 8'h00;
        pe = 8'h00;
        for (int k = 0; k <= BR * BC + 1; k++) begin
            b_en = (k == 0); b_data = b; b_valid = 1'b1;
            p = k - 1;
            r = (p >= 0) ? p / BC : 0;
            c = (p >= 0) ? p % BC : 0;
            rdy = (p >= 0) && (p < BR * BC) && (c >= BOH) && (c != BC - 1);
            #1;
            check_eq("big_ready", b_ready, rdy);
            rdy_dut = b_ready;
            @(posedge clk); #1;
            if (rdy_dut) b = b + 8'd1;
            if (p >= 0 && p < BR * BC) begin
                eb = 8'h00;
                if (r == 0 && c < 3)      eb = 8'hF6;
                else if (r == 0 && c < 6) eb = 8'h28;
                else if (rdy) begin
                    eb = pe;
                    pe = pe + 8'd1;
                end
                check_eq("big_data", b_fdata, eb);
                check_eq("big_valid", b_fvalid, 1);
                check_eq("big_fas", b_ffas, (p == 0));
            end else begin
                check_eq("big_idle_data", b_fdata, 0);
                check_eq("big_idle_valid", b_fvalid, 0);
            end
        end
        check_eq("big_running_end", b_running, 0);
    endtask

    initial begin
        int dropped;
        bit v;
        rst = 1'b1;
        s_en = 0; s_clr = 0; s_valid = 0; s_data = 0;
        b_en = 0; b_clr = 0; b_valid = 0; b_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", s_fdata, 0);
        check_eq("rst_valid", s_fvalid, 0);
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_running", b_running, 0);
        rst = 1'b0;

        $display("[TB] phase: reset/idle");
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'($urandom), 0);
            check_eq("big_idle_ready", b_ready, 0);
            check_eq("big_idle_fvalid", b_fvalid, 0);
        end

        $display("[TB] phase: default-size header frame");
        run_header();

        $display("[TB] phase: MFAS wrap over 257 frames");
        step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < 257 * SR * SC; i++) begin
            step(i != 257 * SR * SC - 1, ($urandom_range(0, 3) != 0), 8'($urandom), 0);
        end
        check_eq("mfas_wrap", s_mfas, 1);
        check_eq("mfas_wrap_running", s_running, 0);
        step(0, 0, 8'h00, 1);

        $display("[TB] phase: underflow");
        dropped = 0;
        step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < SR * SC; i++) begin
            v = !(model_ready() && dropped < 5);
            if (model_ready() && !v) dropped++;
            step(0, v, 8'($urandom), 0);
        end
        check_eq("uf_five", s_ucnt, 5);
        step(0, 0, 8'h00, 1);
        check_eq("uf_cleared", s_ucnt, 0);

        $display("[TB] phase: stop mid-frame");
        step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < SR * SC; i++) step(m_p < 29, 1, 8'($urandom), 0);
        step(0, 1, 8'($urandom), 0);
        check_eq("stop_valid", s_fvalid, 0);
        check_eq("stop_running", s_running, 0);
        step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < SR * SC; i++) step((m_p < 29) || (m_p == SR * SC - 1), 1, 8'($urandom), 0);
        check_eq("b2b_running", s_running, 1);
        for (int i = 0; i < SR * SC; i++) step(0, 1, 8'($urandom), 0);

        $display("[TB] phase: random traffic");
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] phase: async reset mid-payload");
        if (!m_gen) step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < 4 * SR * SC && !(m_gen && m_p == SC + 10); i++) begin
            step(1, ($urandom_range(0, 3) != 0), 8'($urandom), 0);
        end
        check_eq("arst_at_pos", m_p, SC + 10);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_data", s_fdata, 0);
        check_eq("arst_valid", s_fvalid, 0);
        check_eq("arst_fas", s_ffas, 0);
        check_eq("arst_ready", s_ready, 0);
        check_eq("arst_running", s_running, 0);
        check_eq("arst_col", s_col, 0);
        check_eq("arst_mfas", s_mfas, 0);
        check_eq("arst_uf", s_ucnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 1, 8'($urandom), 0);
        step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < SR * SC; i++) step(0, ($urandom_range(0, 3) != 0), 8'($urandom), 0);
        check_eq("post_arst_mfas", s_mfas, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
